// File: rtl/ex_alu_md_sequencer_pkg.sv
// Shared definitions for the EX-stage ALU control and the multiply/divide
// sequencer: ALUOp classes, R-type funct codes, ALU control codes and the
// sequencer state encoding.
package ex_alu_md_sequencer_pkg;

  // Main-control ALU op classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // R-type funct codes that touch HI/LO
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // ALU control codes for the non-R-type classes
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_IMM = 6'b000101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_alu_md_sequencer_alu_ctrl_decode.sv
// Combinational ALU control decode.
// Ports:
//   alu_op   in  2    main-control ALU op class
//   funct    in  OPW  instruction funct field
//   alu_code out OPW  ALU control code
//   is_md    out 1    funct is MULT/MULTU/DIV/DIVU (R-type only)
//   is_hilo  out 1    funct reads or writes HI/LO (R-type only)
module alu_ctrl_decode
  import ex_alu_md_sequencer_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [1:0]     alu_op,
  input  logic [OPW-1:0] funct,
  output logic [OPW-1:0] alu_code,
  output logic           is_md,
  output logic           is_hilo
);

  logic md_range;
  logic mv_range;

  always_comb begin
    md_range = (funct >= OPW'(F_MULT)) && (funct <= OPW'(F_DIVU));
    mv_range = (funct >= OPW'(F_MFHI)) && (funct <= OPW'(F_MTLO));
  end

  always_comb begin
    alu_code = OPW'(ALU_ADD);
    is_md    = 1'b0;
    is_hilo  = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: alu_code = OPW'(ALU_ADD);
      ALUOP_SUB: alu_code = OPW'(ALU_SUB);
      ALUOP_IMM: alu_code = OPW'(ALU_IMM);
      ALUOP_RTYPE: begin
        alu_code = funct;
        is_md    = md_range;
        is_hilo  = md_range | mv_range;
      end
      default: alu_code = OPW'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/ex_alu_md_sequencer.sv
// EX-stage ALU control plus a multicycle multiply/divide sequencer.
// Launches the iterative HI/LO unit, counts its latency, pulses the HI/LO
// write and stalls HI/LO-dependent instructions while the unit is busy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_in, flush   EX-stage instruction valid / squash
//   ALUOpF, funct     decode inputs
//   ALUControlOpcode  ALU control code (combinational)
//   md_start          one-cycle launch pulse
//   md_op             00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held until next launch
//   md_busy           sequencer not IDLE
//   hilo_we           one-cycle HI/LO write strobe
//   stall             hold IF/ID/EX (combinational)
module ex_alu_md_sequencer
  import ex_alu_md_sequencer_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNTW       = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_in,
  input  logic           flush,
  input  logic [1:0]     ALUOpF,
  input  logic [OPW-1:0] funct,
  output logic [OPW-1:0] ALUControlOpcode,
  output logic           md_start,
  output logic [1:0]     md_op,
  output logic           md_busy,
  output logic           hilo_we,
  output logic           stall
);

  md_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            md_start_q, md_start_d;
  logic [1:0]      md_op_q, md_op_d;

  logic is_md;
  logic is_hilo;
  logic accept;

  alu_ctrl_decode #(.OPW(OPW)) u_decode (
    .alu_op   (ALUOpF),
    .funct    (funct),
    .alu_code (ALUControlOpcode),
    .is_md    (is_md),
    .is_hilo  (is_hilo)
  );

  // Flush only blocks a launch; it never hides a stall, so a squashed
  // HI/LO reader still holds the front end until the unit drains.
  always_comb begin
    stall  = valid_in & is_hilo & (state_q != IDLE);
    accept = valid_in & ~flush & is_md & (state_q == IDLE);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = BUSY;
          md_start_d = 1'b1;
          md_op_d    = funct[1:0];
          // funct[1] separates DIV/DIVU from MULT/MULTU
          cnt_d      = funct[1] ? CNTW'(DIV_CYCLES - 1) : CNTW'(MUL_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
    end
  end

  // Status strobes decode straight from the state flop, so they are
  // glitch-free and clear with the asynchronous reset.
  always_comb begin
    md_start = md_start_q;
    md_op    = md_op_q;
    md_busy  = (state_q != IDLE);
    hilo_we  = (state_q == DONE);
  end

endmodule

// File: tb/tb_ex_alu_md_sequencer.sv
module tb_ex_alu_md_sequencer;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic       flush;
  logic [1:0] ALUOpF;
  logic [5:0] funct;
  logic [5:0] ALUControlOpcode;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       hilo_we;
  logic       stall;

  int n_tests;
  int n_fail;

  ex_alu_md_sequencer #(
    .OPW        (6),
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .flush            (flush),
    .ALUOpF           (ALUOpF),
    .funct            (funct),
    .ALUControlOpcode (ALUControlOpcode),
    .md_start         (md_start),
    .md_op            (md_op),
    .md_busy          (md_busy),
    .hilo_we          (hilo_we),
    .stall            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [1:0] op, input logic [5:0] fn);
    valid_in = v;
    flush    = f;
    ALUOpF   = op;
    funct    = fn;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int starts;
  int writes;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 6'h00);
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_md_start", md_start, 0);
    check("rst_md_op", md_op, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_hilo_we", hilo_we, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Decode: non-R-type classes ignore funct, even md funct codes
    drive(1'b1, 1'b0, 2'b00, 6'h18);
    @(negedge clk);
    check("dec_add", ALUControlOpcode, 6'h20);
    next_cycle();
    drive(1'b1, 1'b0, 2'b01, 6'h1A);
    @(negedge clk);
    check("dec_sub", ALUControlOpcode, 6'h22);
    check("dec_no_start", md_start, 0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b11, 6'h12);
    @(negedge clk);
    check("dec_imm", ALUControlOpcode, 6'h05);
    check("dec_imm_stall", stall, 0);
    check("dec_no_start2", md_start, 0);
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 6'h2A);
    @(negedge clk);
    check("dec_rtype", ALUControlOpcode, 6'h2A);
    check("dec_rtype_busy", md_busy, 0);
    check("dec_no_start3", md_start, 0);
    next_cycle();

    // MULT accepted at k=0: start@1, busy 1..5, hilo_we@5; flush at k=3 ignored
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 2'b10, 6'h18);
      else if (k == 3) drive(1'b0, 1'b1, 2'b00, 6'h00);
      else drive(1'b0, 1'b0, 2'b00, 6'h00);
      @(negedge clk);
      check($sformatf("mult_start_k%0d", k), md_start, (k == 1));
      check($sformatf("mult_busy_k%0d", k), md_busy, (k >= 1 && k <= 5));
      check($sformatf("mult_we_k%0d", k), hilo_we, (k == 5));
      if (k == 1) check("mult_op", md_op, 2'b00);
      next_cycle();
    end

    // DIVU at k=0 then MFLO held: stall 1..33, hilo_we@33
    for (int k = 0; k < 36; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 2'b10, 6'h1B);
      else drive(1'b1, 1'b0, 2'b10, 6'h12);
      @(negedge clk);
      check($sformatf("divu_stall_k%0d", k), stall, (k >= 1 && k <= 33));
      check($sformatf("divu_we_k%0d", k), hilo_we, (k == 33));
      if (k == 1) check("divu_op", md_op, 2'b11);
      if (k == 35) check("divu_op_hold", md_op, 2'b11);
      next_cycle();
    end
    drive(1'b0, 1'b0, 2'b00, 6'h00);
    next_cycle();

    // MULT then DIV back-to-back: DIV stalls 1..5, accepted at k=6
    starts = 0;
    writes = 0;
    for (int k = 0; k < 44; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 2'b10, 6'h18);
      else if (k <= 6) drive(1'b1, 1'b0, 2'b10, 6'h1A);
      else drive(1'b0, 1'b0, 2'b00, 6'h00);
      @(negedge clk);
      if (md_start) starts++;
      if (hilo_we) writes++;
      if (k == 1) check("b2b_op_mult", md_op, 2'b00);
      if (k == 5) check("b2b_stall_k5", stall, 1);
      if (k == 6) check("b2b_stall_k6", stall, 0);
      if (k == 7) check("b2b_start_div", md_start, 1);
      if (k == 7) check("b2b_op_div", md_op, 2'b10);
      if (k == 39) check("b2b_we_div", hilo_we, 1);
      if (k == 40) check("b2b_idle", md_busy, 0);
      next_cycle();
    end
    check("b2b_starts", starts, 2);
    check("b2b_writes", writes, 2);

    // Flush in the accept cycle blocks the launch
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 2'b10, 6'h1A);
      else drive(1'b0, 1'b0, 2'b00, 6'h00);
      @(negedge clk);
      check($sformatf("flush_start_k%0d", k), md_start, 0);
      check($sformatf("flush_busy_k%0d", k), md_busy, 0);
      next_cycle();
    end

    // Reset mid-BUSY on a DIV abandons the op
    drive(1'b1, 1'b0, 2'b10, 6'h1A);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 6'h00);
    @(negedge clk);
    check("rstmid_start", md_start, 1);
    repeat (10) next_cycle();
    #1;
    check("rstmid_busy_pre", md_busy, 1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", md_busy, 0);
    check("rstmid_op", md_op, 0);
    check("rstmid_start0", md_start, 0);
    check("rstmid_we", hilo_we, 0);
    repeat (2) next_cycle();
    rst = 1'b0;
    writes = 0;
    starts = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_we) writes++;
      if (md_busy) starts++;
      next_cycle();
    end
    check("rstmid_no_we", writes, 0);
    check("rstmid_no_busy", starts, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
